// File: rtl/count_run_ctrl.sv
// Run/pause/step sequencer: button press detection, programmable tick divider and wrapping counter.
// Optional: define COUNT_RUN_CTRL_AUTOSTOP_EN to drop from RUN to PAUSE on the wrapping tick.
module count_run_ctrl #(
  parameter int DIV_SIZE    = 5,
  parameter int DIV_DEFAULT = 5,
  parameter int CNT_SIZE    = 2,
  parameter int CNT_MAX     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                stop_btn,
  input  logic                step_btn,
  input  logic [DIV_SIZE-1:0] div_sel,
  input  logic                div_load,
  output logic                tick,
  output logic [CNT_SIZE-1:0] count,
  output logic                wrap,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    STEP  = 2'b11
  } mode_t;

  localparam logic [DIV_SIZE-1:0] RATIO_RST = DIV_SIZE'(DIV_DEFAULT);
  localparam logic [DIV_SIZE-1:0] DIV_ONE   = DIV_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] CNT_TOP   = CNT_SIZE'(CNT_MAX);
  localparam logic [CNT_SIZE-1:0] CNT_ONE   = CNT_SIZE'(1);

  mode_t               mode_q, mode_n;
  logic [DIV_SIZE-1:0] div_q, div_n;
  logic [DIV_SIZE-1:0] ratio_q, ratio_n;
  logic [CNT_SIZE-1:0] cnt_n;
  logic                tick_n, wrap_n, adv;

  // Button order in the vectors: {step, stop, start}
  logic [2:0] btn_now, btn_lvl_q, btn_prev_q, btn_arm_q, press;
  logic       start_ev, stop_ev, step_ev;

  assign btn_now = {step_btn, stop_btn, start_btn};
  // Arm only after a button has been seen low, so a level held through reset release is not a press.
  assign press    = btn_lvl_q & ~btn_prev_q & btn_arm_q;
  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign step_ev  = press[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_lvl_q  <= '0;
      btn_prev_q <= '0;
      btn_arm_q  <= '0;
    end else begin
      btn_lvl_q  <= btn_now;
      btn_prev_q <= btn_lvl_q;
      btn_arm_q  <= btn_arm_q | ~btn_now;
    end
  end

  always_comb begin
    mode_n  = mode_q;
    div_n   = div_q;
    ratio_n = ratio_q;
    cnt_n   = count;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    adv     = 1'b0;

    unique case (mode_q)
      IDLE: begin
        div_n = '0;
        cnt_n = '0;
        if (start_ev) mode_n = RUN;
      end
      RUN: begin
        if (stop_ev) begin
          mode_n = PAUSE;
        end else if (div_q == ratio_q - DIV_ONE) begin
          div_n = '0;
          adv   = 1'b1;
        end else begin
          div_n = div_q + DIV_ONE;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          mode_n = IDLE;
          div_n  = '0;
          cnt_n  = '0;
        end else if (start_ev) begin
          mode_n = RUN;
        end else if (step_ev) begin
          mode_n = STEP;
          adv    = 1'b1;
        end
      end
      STEP: mode_n = PAUSE;
      default: mode_n = IDLE;
    endcase

    if (adv) begin
      tick_n = 1'b1;
      if (count == CNT_TOP) begin
        cnt_n  = '0;
        wrap_n = 1'b1;
`ifdef COUNT_RUN_CTRL_AUTOSTOP_EN
        if (mode_q == RUN) mode_n = PAUSE;
`else
        mode_n = mode_n;
`endif
      end else begin
        cnt_n = count + CNT_ONE;
      end
    end

    // A load overrides the divider update from the mode logic above.
    if (div_load && (mode_q == IDLE || mode_q == PAUSE)) begin
      ratio_n = (div_sel == '0) ? DIV_ONE : div_sel;
      div_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= IDLE;
      div_q   <= '0;
      ratio_q <= RATIO_RST;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      mode_q  <= mode_n;
      div_q   <= div_n;
      ratio_q <= ratio_n;
      count   <= cnt_n;
      tick    <= tick_n;
      wrap    <= wrap_n;
    end
  end

  assign state = mode_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Self-checking bench for count_run_ctrl: directed scenarios plus randomized buttons/loads vs a reference model.
module tb_count_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, stop_btn, step_btn, div_load;
  logic [4:0] div_sel;
  logic       tick, wrap;
  logic [1:0] count, state;

  int checks = 0;
  int fails  = 0;

  // Reference model: mode 0 IDLE, 1 RUN, 2 PAUSE, 3 STEP; phase = clocks since last tick.
  int m_mode, m_phase, m_cnt, m_ratio, m_tick, m_wrap;
  int m_r[3], m_p[3], m_arm[3];

  count_run_ctrl #(.DIV_SIZE(5), .DIV_DEFAULT(5), .CNT_SIZE(2), .CNT_MAX(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .step_btn(step_btn), .div_sel(div_sel), .div_load(div_load),
    .tick(tick), .count(count), .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_ratio = 5; m_tick = 0; m_wrap = 0;
    for (int i = 0; i < 3; i++) begin
      m_r[i] = 0; m_p[i] = 0; m_arm[i] = 0;
    end
  endtask

  task automatic model_clock();
    bit ev[3];
    int btn[3];
    int old;
    bit adv;
    btn[0] = int'(start_btn); btn[1] = int'(stop_btn); btn[2] = int'(step_btn);
    for (int i = 0; i < 3; i++) ev[i] = (m_r[i] == 1 && m_p[i] == 0 && m_arm[i] == 1);
    old = m_mode; m_tick = 0; m_wrap = 0; adv = 0;
    case (old)
      0: if (ev[0]) m_mode = 1;
      1: begin
        if (ev[1]) m_mode = 2;
        else if (m_phase == m_ratio - 1) begin m_phase = 0; adv = 1; end
        else m_phase = m_phase + 1;
      end
      2: begin
        if (ev[1]) begin m_mode = 0; m_cnt = 0; m_phase = 0; end
        else if (ev[0]) m_mode = 1;
        else if (ev[2]) begin m_mode = 3; adv = 1; end
      end
      default: m_mode = 2;
    endcase
    if (adv) begin
      m_tick = 1;
      if (m_cnt == 3) begin
        m_wrap = 1;
`ifdef COUNT_RUN_CTRL_AUTOSTOP_EN
        if (old == 1) m_mode = 2;
`endif
      end
      m_cnt = (m_cnt + 1) % 4;
    end
    if (div_load && (old == 0 || old == 2)) begin
      m_ratio = (div_sel == 0) ? 1 : int'(div_sel);
      m_phase = 0;
    end
    for (int i = 0; i < 3; i++) begin
      m_p[i] = m_r[i];
      m_r[i] = btn[i];
      if (btn[i] == 0) m_arm[i] = 1;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {2'(m_mode), 2'(m_cnt), 1'(m_tick), 1'(m_wrap)};
  endfunction

  task automatic clk_cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    start_btn = 1'b1; stop_btn = 1'b0; step_btn = 1'b0; div_load = 1'b0; div_sel = '0;
    reset = 1'b1;
    #12 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({state, count, tick, wrap} !== 6'b0) begin
      fails++; $display("FAIL reset_values got=%b exp=%b", {state, count, tick, wrap}, 6'b0);
    end
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk_cycle();
      checks++;
      if ({state, count, tick, wrap} !== exp_vec() || state !== 2'b00) begin
        fails++; $display("FAIL reset_held_start k=%0d got=%b exp=%b", k, {state, count, tick, wrap}, exp_vec());
      end
    end
  endtask

  task automatic test_run();
    start_btn = 1'b0;
    repeat (2) clk_cycle();
    start_btn = 1'b1;
    clk_cycle();
    checks++;
    if (state !== 2'b00) begin fails++; $display("FAIL run_not_yet got=%b exp=00", state); end
    clk_cycle();
    checks++;
    if (state !== 2'b01) begin fails++; $display("FAIL run_enter got=%b exp=01", state); end
    start_btn = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      clk_cycle();
      checks++;
      if (tick !== (k % 5 == 0) || count !== 2'((k / 5) % 4) || wrap !== (k == 20) ||
          {state, count, tick, wrap} !== exp_vec()) begin
        fails++;
        $display("FAIL run_ticks k=%0d got=%b exp=%b", k, {state, count, tick, wrap}, exp_vec());
      end
    end
  endtask

  task automatic test_pause_resume();
    logic [1:0] frozen;
    int guard = 0;
    while (m_phase != 2 && guard < 10) begin clk_cycle(); guard++; end
    checks++;
    if (guard >= 10) begin fails++; $display("FAIL pause_seek got=timeout exp=phase2"); end
    stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    checks++;
    if (state !== 2'b10 || {state, count, tick, wrap} !== exp_vec()) begin
      fails++; $display("FAIL pause_enter got=%b exp=%b", {state, count, tick, wrap}, exp_vec());
    end
    stop_btn = 1'b0;
    frozen = count;
    for (int k = 0; k < 4; k++) begin
      clk_cycle();
      checks++;
      if (state !== 2'b10 || count !== frozen || tick !== 1'b0) begin
        fails++; $display("FAIL pause_frozen k=%0d got=%b/%b exp=10/%b", k, state, count, frozen);
      end
    end
    start_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    checks++;
    if (state !== 2'b01) begin fails++; $display("FAIL resume_state got=%b exp=01", state); end
    start_btn = 1'b0;
    clk_cycle();
    checks++;
    if (tick !== 1'b0) begin fails++; $display("FAIL resume_early got=%b exp=0", tick); end
    clk_cycle();
    checks++;
    if (tick !== 1'b1 || {state, count, tick, wrap} !== exp_vec()) begin
      fails++; $display("FAIL resume_tick got=%b exp=%b", {state, count, tick, wrap}, exp_vec());
    end
  endtask

  task automatic test_step();
    int guard = 0;
    while (!(m_cnt == 1 && m_phase == 0 && m_mode == 1) && guard < 40) begin clk_cycle(); guard++; end
    stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    stop_btn = 1'b0;
    checks++;
    if (state !== 2'b10 || count !== 2'd1) begin
      fails++; $display("FAIL step_setup got=%b/%b exp=10/01", state, count);
    end
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      clk_cycle();
      clk_cycle();
      checks++;
      if ({state, count, tick, wrap} !== {2'b11, 2'((2 + i) % 4), 1'b1, 1'(i == 2)} ||
          {state, count, tick, wrap} !== exp_vec()) begin
        fails++; $display("FAIL step_pulse i=%0d got=%b exp=%b", i, {state, count, tick, wrap}, exp_vec());
      end
      step_btn = 1'b0;
      clk_cycle();
      checks++;
      if (state !== 2'b10 || tick !== 1'b0 || wrap !== 1'b0) begin
        fails++; $display("FAIL step_return i=%0d got=%b exp=10/0/0", i, {state, tick, wrap});
      end
      clk_cycle();
    end
    stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    stop_btn = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 2'd0) begin
      fails++; $display("FAIL step_to_idle got=%b/%b exp=00/00", state, count);
    end
  endtask

  task automatic test_div_load();
    int k = 0;
    div_sel = 5'd2; div_load = 1'b1;
    clk_cycle();
    div_load = 1'b0;
    start_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    start_btn = 1'b0;
    checks++;
    if (state !== 2'b01) begin fails++; $display("FAIL div2_run got=%b exp=01", state); end
    for (int n = 0; n < 16; n++) begin
      if (n == 8) begin div_sel = 5'd7; div_load = 1'b1; end
      clk_cycle();
      div_load = 1'b0;
      k++;
      checks++;
      if (tick !== (k % 2 == 0) || {state, count, tick, wrap} !== exp_vec()) begin
        fails++; $display("FAIL div2_period k=%0d got=%b exp=%b", k, {state, count, tick, wrap}, exp_vec());
      end
    end
    stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    stop_btn = 1'b0;
    div_sel = 5'd0; div_load = 1'b1;
    clk_cycle();
    div_load = 1'b0;
    start_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    start_btn = 1'b0;
    for (int n = 0; n < 6; n++) begin
      clk_cycle();
      checks++;
      if (tick !== 1'b1 || {state, count, tick, wrap} !== exp_vec()) begin
        fails++; $display("FAIL div0_every n=%0d got=%b exp=%b", n, {state, count, tick, wrap}, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    stop_btn = 1'b0;
    clk_cycle();
    start_btn = 1'b1; stop_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    start_btn = 1'b0; stop_btn = 1'b0;
    checks++;
    if (state !== 2'b00 || count !== 2'd0 || {state, count, tick, wrap} !== exp_vec()) begin
      fails++; $display("FAIL stop_wins got=%b exp=%b", {state, count, tick, wrap}, exp_vec());
    end
  endtask

  task automatic test_autostop();
    int ticks = 0;
    @(negedge clk) reset = 1'b0;
    #1 model_reset();
    @(negedge clk) reset = 1'b1;
    clk_cycle();
    start_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    start_btn = 1'b0;
    for (int k = 0; k < 25; k++) begin
      clk_cycle();
      if (tick === 1'b1) ticks++;
      checks++;
      if ({state, count, tick, wrap} !== exp_vec()) begin
        fails++; $display("FAIL autostop_cycle k=%0d got=%b exp=%b", k, {state, count, tick, wrap}, exp_vec());
      end
    end
    checks++;
`ifdef COUNT_RUN_CTRL_AUTOSTOP_EN
    if (ticks != 4 || state !== 2'b10 || count !== 2'd0) begin
      fails++; $display("FAIL autostop_end got=%0d/%b/%b exp=4/10/00", ticks, state, count);
    end
`else
    if (ticks != 5 || state !== 2'b01) begin
      fails++; $display("FAIL freerun_end got=%0d/%b exp=5/01", ticks, state);
    end
`endif
  endtask

  task automatic test_async_reset();
    start_btn = 1'b1;
    clk_cycle();
    clk_cycle();
    start_btn = 1'b0;
    repeat (7) clk_cycle();
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({state, count, tick, wrap} !== 6'b0) begin
      fails++; $display("FAIL async_reset got=%b exp=000000", {state, count, tick, wrap});
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(4) == 0) start_btn = ~start_btn;
      if ($urandom_range(6) == 0) stop_btn  = ~stop_btn;
      if ($urandom_range(4) == 0) step_btn  = ~step_btn;
      div_load = ($urandom_range(11) == 0);
      div_sel  = 5'($urandom_range(7));
      if (n % 150 == 149) begin
        #2 reset = 1'b0;
        #1 model_reset();
        @(negedge clk) reset = 1'b1;
      end
      clk_cycle();
      checks++;
      if ({state, count, tick, wrap} !== exp_vec()) begin
        fails++; $display("FAIL random n=%0d got=%b exp=%b", n, {state, count, tick, wrap}, exp_vec());
      end
    end
    start_btn = 1'b0; stop_btn = 1'b0; step_btn = 1'b0; div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause_resume();
    test_step();
    test_div_load();
    test_simultaneous();
    test_autostop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/count_run_ctrl.md
Name: count_run_ctrl

Overview:
- Run/pause/step sequencer for the divided 2-bit counter datapath.
- Takes debounced push-button levels and converts them to one-cycle press events.
- Holds a programmable divide ratio and generates a one-cycle tick strobe at clk/ratio while running.
- Owns the counter value, its wrap pulse and the current mode; replaces free-running divider and counter enabling at top level.

Parameters:
- DIV_SIZE, 5, width of the divide-ratio register and the internal divider counter.
- DIV_DEFAULT, 5, divide ratio loaded at reset (tick every DIV_DEFAULT clocks).
- CNT_SIZE, 2, width of count output.
- CNT_MAX, 3, terminal count value; count wraps CNT_MAX -> 0.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_btn  input  1  debounced start level.
- stop_btn  input  1  debounced stop level.
- step_btn  input  1  debounced single-step level.
- div_sel  input  DIV_SIZE  new divide ratio.
- div_load  input  1  load strobe for div_sel.
- tick  output  1  one-cycle enable strobe; count advances on the same edge.
- count  output  CNT_SIZE  current count.
- wrap  output  1  one-cycle pulse, coincident with tick, when count goes CNT_MAX -> 0.
- state  output  2  mode: 00 IDLE, 01 RUN, 10 PAUSE, 11 STEP.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, tick=0, wrap=0.
  - Divider counter = 0; ratio register = DIV_DEFAULT.
  - Button history registers = 0, so a button held through reset release does not produce an event.
- Press events:
  - Event = rising edge of the registered button level; exactly one event per press.
  - An event acts on the FSM in the cycle after the button goes high.
  - Priority for simultaneous events: stop > start > step.
- IDLE:
  - count and divider held at 0; tick=0.
  - start -> RUN. stop and step ignored.
- RUN:
  - Divider increments each clock.
  - When divider == ratio-1: divider -> 0, tick=1 for that cycle, count+1.
  - First tick occurs ratio clocks after entering RUN.
  - stop -> PAUSE; divider and count frozen at current values.
  - start and step ignored.
- PAUSE:
  - start -> RUN; divider resumes from its frozen value.
  - step -> STEP.
  - stop -> IDLE; count and divider cleared.
- STEP:
  - Lasts exactly one cycle: tick=1, count+1, divider unchanged, then PAUSE unconditionally.
  - Events in this cycle are lost.
- Ratio register:
  - div_load accepted only in IDLE or PAUSE; ignored in RUN and STEP.
  - div_sel=0 is stored as 1 (tick every clock).
  - On load, divider resets to 0.
- Count arithmetic:
  - Unsigned; count==CNT_MAX on tick -> 0 with wrap=1.
  - Otherwise wrap=0.
- tick, wrap and state are registered outputs; there is no combinational path from any input to any output.
- Reset asserted mid-RUN: all outputs go to reset values immediately (asynchronously).

Optional Feature:
- Macro: COUNT_RUN_CTRL_AUTOSTOP_EN.
- Defined: in RUN, the tick that wraps the count (wrap=1) also moves state to PAUSE on the same edge, giving a one-shot cycle of CNT_MAX+1 ticks. The next start resumes.
- Undefined: RUN free-runs through wraps until stop.

Test Plan:
- Reset, release with start_btn already high -> no event, state stays 00. Drop and re-raise start -> state 01 one cycle after the rise. First tick 5 clocks later; ticks every 5 clocks; count 0,1,2,3,0 with wrap on the 4th tick.
- RUN, stop pressed with divider=2 -> state 10, count frozen. Later start -> next tick exactly 2 clocks after state returns to 01.
- PAUSE with count=1, press step 3 times -> each press: state 11 for one cycle, tick=1, count 2,3,0, wrap on the third, return to 10. stop -> state 00, count 0.
- IDLE, div_sel=2, div_load=1 -> ticks every 2 clocks in RUN. div_load with div_sel=7 during RUN -> ratio unchanged. div_sel=0 loaded in PAUSE -> tick every clock after start.
- start and stop rise in the same cycle while in PAUSE -> state 00 (stop wins).
- With COUNT_RUN_CTRL_AUTOSTOP_EN, ratio 5, start from count 0 -> 4 ticks, state 10 after the wrap tick, count 0. Without the macro -> still 01.
